// File: rtl/ins_fetch_unit_if.sv
// Handshake bundle shared by the fetch stage, instruction memory and decode.
interface ins_fetch_unit_if;
  logic        IMEM_req_valid;
  logic [31:0] IMEM_req_address;
  logic        IMEM_req_ready;
  logic        IMEM_resp_valid;
  logic [31:0] IMEM_resp_data;
  logic        ins_valid;
  logic [31:0] instruction;
  logic [31:0] PC;
  logic        ins_ready;
  logic        redirect_valid;
  logic [31:0] redirect_PC;
  logic        misaligned_redirect;

  modport master (
    output IMEM_req_valid,
    output IMEM_req_address,
    input  IMEM_req_ready,
    input  IMEM_resp_valid,
    input  IMEM_resp_data,
    output ins_valid,
    output instruction,
    output PC,
    input  ins_ready,
    input  redirect_valid,
    input  redirect_PC,
    output misaligned_redirect
  );

  modport slave (
    input  IMEM_req_valid,
    input  IMEM_req_address,
    output IMEM_req_ready,
    output IMEM_resp_valid,
    output IMEM_resp_data,
    input  ins_valid,
    input  instruction,
    input  PC,
    output ins_ready,
    output redirect_valid,
    output redirect_PC,
    input  misaligned_redirect
  );
endinterface

// File: rtl/ins_fetch_unit.sv
// Instruction fetch: in-order word requests, PC-tagged response FIFO,
// redirect flush with discard of in-flight responses.
module ins_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input logic              SYS_clk,
  input logic              SYS_reset,
  ins_fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t        state;
  logic          active;
  logic          misaligned;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] drop_next;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];

  logic        redirect;
  logic        credit;
  logic        req_valid;
  logic        accept;
  logic        resp_ok;
  logic        push;
  logic        pop;
  logic [31:0] resp_pc;

  assign redirect  = bus.redirect_valid;
  assign credit    = (32'(count) + 32'(outstanding)) < 32'(DEPTH);
  assign req_valid = active && (state == FETCH)
                  && credit && !redirect;
  assign accept    = req_valid && bus.IMEM_req_ready;

  // Responses with nothing to account for are protocol violations.
  assign resp_ok = bus.IMEM_resp_valid
                && ((state == FETCH) ? (outstanding != '0)
                                     : (drop_count != '0));
  assign push    = (state == FETCH) && resp_ok && !redirect;
  assign pop     = (count != '0) && bus.ins_ready && !redirect;

  // Requests are sequential, so the oldest in-flight PC trails fetch_pc.
  assign resp_pc   = fetch_pc - 32'({outstanding, 2'b00});
  assign drop_next = drop_count + outstanding - CW'(resp_ok);

  assign bus.IMEM_req_valid      = req_valid;
  assign bus.IMEM_req_address    = active ? fetch_pc : 32'h0;
  assign bus.ins_valid           = (count != '0);
  assign bus.instruction         = ins_mem[rd_ptr];
  assign bus.PC                  = pc_mem[rd_ptr];
  assign bus.misaligned_redirect = misaligned;

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state       <= FETCH;
      active      <= 1'b0;
      misaligned  <= 1'b0;
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else begin
      active <= 1'b1;
      if (redirect) begin
        fetch_pc    <= {bus.redirect_PC[31:2], 2'b00};
        count       <= '0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        outstanding <= '0;
        drop_count  <= drop_next;
        state       <= (drop_next != '0) ? FLUSH : FETCH;
        if (bus.redirect_PC[1:0] != 2'b00)
          misaligned <= 1'b1;
      end else begin
        if (accept)
          fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          pc_mem[wr_ptr]  <= resp_pc;
          ins_mem[wr_ptr] <= bus.IMEM_resp_data;
          wr_ptr          <= wr_ptr + AW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count       <= count + CW'(push) - CW'(pop);
        outstanding <= outstanding + CW'(accept) - CW'(push);
        if ((state == FLUSH) && resp_ok) begin
          drop_count <= drop_count - CW'(1);
          if (drop_count == CW'(1))
            state <= FETCH;
        end
      end
    end
  end
endmodule

// File: tb/tb_ins_fetch_unit.sv
// Bench for ins_fetch_unit: memory model, PC/data scoreboard,
// redirect vector table and hand-written flush/reset sequences.
module tb_ins_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ins_fetch_unit_if bus();

  ins_fetch_unit #(
    .RESET_PC(RST_PC),
    .DEPTH   (4)
  ) dut (
    .SYS_clk  (clk),
    .SYS_reset(rst_n),
    .bus      (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic        mis;
  } vec_t;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int lat    = 1;
  int n_req  = 0;
  int r      = 0;
  logic [31:0] exp_addr = RST_PC;

  mreq_t       mq[$];
  exp_t        sb[$];
  logic [31:0] acc_a[$];
  int          acc_c[$];
  int          pop_c[$];
  logic [31:0] pop_pc[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_logs();
    acc_a.delete();
    acc_c.delete();
    pop_c.delete();
    pop_pc.delete();
  endtask

  task automatic tick();
    mreq_t m;
    exp_t  e;
    @(negedge clk);
    if (bus.redirect_valid)
      chk("req_gated", {31'd0, bus.IMEM_req_valid}, 32'd0);
    if (bus.IMEM_req_valid && bus.IMEM_req_ready) begin
      chk("req_addr", bus.IMEM_req_address, exp_addr);
      m.addr = bus.IMEM_req_address;
      m.due  = cyc + lat;
      mq.push_back(m);
      e.pc  = m.addr;
      e.ins = memf(m.addr);
      sb.push_back(e);
      acc_a.push_back(m.addr);
      acc_c.push_back(cyc);
      exp_addr = exp_addr + 32'd4;
      n_req++;
    end
    if (bus.ins_valid && bus.ins_ready && !bus.redirect_valid) begin
      pop_c.push_back(cyc);
      pop_pc.push_back(bus.PC);
      chk("pop_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc", bus.PC, e.pc);
        chk("ins", bus.instruction, e.ins);
      end
    end
    if (bus.redirect_valid) begin
      sb.delete();
      exp_addr = {bus.redirect_PC[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.IMEM_resp_valid = 1'b0;
    bus.IMEM_resp_data  = '0;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      bus.IMEM_resp_valid = 1'b1;
      bus.IMEM_resp_data  = memf(m.addr);
    end
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    bus.IMEM_req_ready  = 1'b1;
    bus.IMEM_resp_valid = 1'b0;
    bus.IMEM_resp_data  = '0;
    bus.ins_ready       = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_PC     = '0;
    mq.delete();
    sb.delete();
    clear_logs();
    n_req    = 0;
    exp_addr = RST_PC;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'd0, bus.IMEM_req_valid}, 32'd0);
    chk({tag, "_req_addr"}, bus.IMEM_req_address, 32'd0);
    chk({tag, "_ins_valid"}, {31'd0, bus.ins_valid}, 32'd0);
    chk({tag, "_instruction"}, bus.instruction, 32'd0);
    chk({tag, "_pc"}, bus.PC, 32'd0);
    chk({tag, "_misaligned"}, {31'd0, bus.misaligned_redirect}, 32'd0);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_PC    = target;
    r = cyc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    vec_t vt[4];
    vt[0] = '{32'h0000_0400, 32'h0000_0400, 32'h0000_0404, 1'b0};
    vt[1] = '{32'h0000_0803, 32'h0000_0800, 32'h0000_0804, 1'b1};
    vt[2] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1004, 1'b1};
    vt[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

    // Reset values, then a zero-wait stream
    #3;
    hold_reset();
    #4;
    check_reset_outputs("rst");
    release_reset();
    lat = 1;
    for (int k = 0; k < 40 && pop_c.size() < 11; k++) tick();
    chk("stream_len", {31'd0, pop_c.size() >= 11}, 32'd1);
    if (pop_c.size() >= 11 && acc_c.size() != 0) begin
      chk("first_req", acc_a[0], RST_PC);
      chk("first_lat", pop_c[0] - acc_c[0], 32'd2);
      chk("rate", pop_c[10] - pop_c[0], 32'd10);
      chk("pc_10", pop_pc[10], RST_PC + 32'd40);
    end

    // Backpressure
    hold_reset();
    release_reset();
    bus.ins_ready = 1'b0;
    repeat (10) tick();
    chk("bp_reqs", n_req, 32'd4);
    chk("bp_req_valid", {31'd0, bus.IMEM_req_valid}, 32'd0);
    chk("bp_head_valid", {31'd0, bus.ins_valid}, 32'd1);
    chk("bp_head_pc", bus.PC, RST_PC);
    chk("bp_head_ins", bus.instruction, memf(RST_PC));
    bus.ins_ready = 1'b1;
    for (int k = 0; k < 30 && pop_c.size() < 10; k++) tick();
    chk("bp_pops", {31'd0, pop_c.size() >= 10}, 32'd1);
    if (pop_c.size() >= 10)
      chk("bp_pc_9", pop_pc[9], RST_PC + 32'd36);

    // Redirect with three requests in flight, latency 4
    hold_reset();
    release_reset();
    lat = 4;
    for (int k = 0; k < 20 && n_req < 3; k++) tick();
    chk("rd_setup", n_req, 32'd3);
    clear_logs();
    redirect_to(32'h0000_2000);
    for (int k = 0; k < 30 && pop_c.size() < 3; k++) tick();
    chk("rd_progress",
        {31'd0, acc_c.size() != 0 && pop_pc.size() != 0}, 32'd1);
    if (acc_c.size() != 0 && pop_pc.size() != 0) begin
      chk("rd_resume", acc_c[0] - r, 32'd4);
      chk("rd_first_pc", pop_pc[0], 32'h0000_2000);
    end

    // Redirect, pop and response in the same cycle
    hold_reset();
    release_reset();
    lat = 2;
    repeat (8) tick();
    chk("sim_resp", {31'd0, bus.IMEM_resp_valid}, 32'd1);
    chk("sim_head", {31'd0, bus.ins_valid}, 32'd1);
    clear_logs();
    redirect_to(32'h0000_3000);
    chk("sim_flushed", {31'd0, bus.ins_valid}, 32'd0);
    for (int k = 0; k < 30 && pop_c.size() < 3; k++) tick();
    chk("sim_progress",
        {31'd0, acc_c.size() != 0 && pop_pc.size() != 0}, 32'd1);
    if (acc_c.size() != 0 && pop_pc.size() != 0) begin
      chk("sim_resume", acc_c[0] - r, 32'd2);
      chk("sim_first_pc", pop_pc[0], 32'h0000_3000);
    end

    // Redirect table from an idle pipe: alignment, sticky flag, wrap
    hold_reset();
    release_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) begin
      bus.IMEM_req_ready = 1'b0;
      repeat (4) tick();
      bus.IMEM_req_ready = 1'b1;
      clear_logs();
      redirect_to(vt[i].target);
      for (int k = 0; k < 20 && (acc_a.size() < 2 || pop_c.size() < 1); k++)
        tick();
      chk("tbl_progress",
          {31'd0, acc_a.size() >= 2 && pop_c.size() != 0}, 32'd1);
      if (acc_a.size() >= 2 && pop_c.size() != 0) begin
        chk("tbl_addr0", acc_a[0], vt[i].addr0);
        chk("tbl_addr1", acc_a[1], vt[i].addr1);
        chk("tbl_req_lat", acc_c[0] - r, 32'd1);
        chk("tbl_valid_lat", pop_c[0] - r, 32'd3);
      end
      chk("tbl_misaligned", {31'd0, bus.misaligned_redirect},
          {31'd0, vt[i].mis});
    end

    // Asynchronous reset while flushing
    hold_reset();
    release_reset();
    lat = 4;
    for (int k = 0; k < 20 && n_req < 3; k++) tick();
    redirect_to(32'h0000_5001);
    chk("ar_mis_set", {31'd0, bus.misaligned_redirect}, 32'd1);
    #2;
    hold_reset();
    #1;
    check_reset_outputs("ar");
    release_reset();
    lat = 1;
    for (int k = 0; k < 30 && pop_c.size() < 3; k++) tick();
    chk("ar_progress",
        {31'd0, acc_a.size() != 0 && pop_pc.size() != 0}, 32'd1);
    if (acc_a.size() != 0 && pop_pc.size() != 0) begin
      chk("ar_first_req", acc_a[0], RST_PC);
      chk("ar_first_pc", pop_pc[0], RST_PC);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far",
             passed, total);
    $fatal(1, "watchdog");
  end
endmodule
